// File: rtl/fpsub_pkg.sv
// Shared constants for the fully pipelined subtractor.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: FPSUB_WIDTH (default operand width), LATENCY / fpsub_latency()
// giving the number of enabled cycles from input to result.
package fpsub_pkg;

    localparam int FPSUB_WIDTH = 4;

    // One full-subtractor cell per stage, so latency tracks the width.
    function automatic int fpsub_latency(input int width);
        return width;
    endfunction

    localparam int LATENCY = fpsub_latency(FPSUB_WIDTH);

endpackage

// File: rtl/dffe.sv
// Enable flip-flop bank with asynchronous active-high clear.
// Latency: 1 cycle when en=1.
// Backpressure: en=0 holds q unchanged.
// Ports: clk, rst (async clear), en (load enable), d (next value), q (state).
module dffe #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell: d = a - b - bi, with borrow out bo.
// Latency: combinational.
// Backpressure: none.
// Ports: bo (borrow out), d (difference bit), a, b (operand bits), bi (borrow in).
module fullsubtractor (
    output logic bo,
    output logic d,
    input  logic a,
    input  logic b,
    input  logic bi
);

    // The a^b term feeds both the sum bit and the borrow propagate path.
    logic x;

    assign x  = a ^ b;
    assign d  = x ^ bi;
    assign bo = (~a & b) | (~x & bi);

endmodule

// File: rtl/fully_pipelined_subtractor.sv
// Bit-serial-in-space subtractor: one register stage per bit, ripple borrow between stages.
// Latency: WIDTH enabled cycles from input presentation to d/bout/out_valid; one op per enabled cycle.
// Backpressure: en=0 freezes every stage register; outputs hold for the whole stall.
// Ports: clk, rst (async, active-high), en, in_valid, a, b, bin -> d, bout, out_valid
// [, ovf when FPSUB_OVERFLOW_EN is defined: signed overflow, registered with d].
module fully_pipelined_subtractor
    import fpsub_pkg::*;
#(
    parameter int WIDTH = FPSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             out_valid
`ifdef FPSUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("fully_pipelined_subtractor: WIDTH must be within 2..64");
    end

    // Stage i resolves bit i of the partial word. Bits above i still hold the
    // original minuend bits, bits below i hold already-resolved difference bits.
    // Only the b bits not yet consumed travel down the pipe, so the b register
    // narrows by one bit per stage and disappears after the last stage.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic [WIDTH-1:0]   p_in;
        logic [WIDTH-1:0]   p_nxt;
        logic [WIDTH-1:0]   p_q;
        logic [WIDTH-i-1:0] b_in;
        logic               br_in;
        logic               br_out;
        logic               br_q;
        logic               vld_in;
        logic               vld_q;
        logic               d_bit;

        if (i == 0) begin : g_first
            assign p_in   = a;
            assign b_in   = b;
            assign br_in  = bin;
            assign vld_in = in_valid;
        end else begin : g_next
            assign p_in   = g_stage[i-1].p_q;
            assign b_in   = g_stage[i-1].g_b.b_q;
            assign br_in  = g_stage[i-1].br_q;
            assign vld_in = g_stage[i-1].vld_q;
        end

        fullsubtractor u_cell (
            .bo (br_out),
            .d  (d_bit),
            .a  (p_in[i]),
            .b  (b_in[0]),
            .bi (br_in)
        );

        always_comb begin
            p_nxt    = p_in;
            p_nxt[i] = d_bit;
        end

        dffe #(.W(WIDTH + 2)) u_stage_reg (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   ({vld_in, br_out, p_nxt}),
            .q   ({vld_q,  br_q,   p_q})
        );

        if (i < WIDTH - 1) begin : g_b
            logic [WIDTH-i-2:0] b_q;

            dffe #(.W(WIDTH - i - 1)) u_b_reg (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .d   (b_in[WIDTH-i-1:1]),
                .q   (b_q)
            );
        end
    end

    assign d         = g_stage[WIDTH-1].p_q;
    assign bout      = g_stage[WIDTH-1].br_q;
    assign out_valid = g_stage[WIDTH-1].vld_q;

`ifdef FPSUB_OVERFLOW_EN
    // The minuend sign sits untouched in the partial word's top bit and the
    // subtrahend sign is the last surviving b bit, so both signs arrive at the
    // final stage without dedicated carry registers.
    logic sign_a;
    logic sign_b;
    logic ovf_nxt;

    assign sign_a  = g_stage[WIDTH-1].p_in[WIDTH-1];
    assign sign_b  = g_stage[WIDTH-1].b_in[0];
    assign ovf_nxt = (sign_a != sign_b) && (g_stage[WIDTH-1].d_bit != sign_a);

    dffe #(.W(1)) u_ovf_reg (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (ovf_nxt),
        .q   (ovf)
    );
`endif

endmodule

// File: tb/tb_fully_pipelined_subtractor.sv
module tb_fully_pipelined_subtractor;
    import fpsub_pkg::*;

    localparam int W = FPSUB_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         out_valid;
`ifdef FPSUB_OVERFLOW_EN
    logic         ovf;
`endif

    fully_pipelined_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .d         (d),
        .bout      (bout),
        .out_valid (out_valid)
`ifdef FPSUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   ecnt   = 0;   // enabled, non-reset clock edges seen so far
    int   last_ecnt = 0;

    always @(posedge clk) begin
        if (!rst && en) ecnt <= ecnt + 1;
    end

    function automatic logic ovf_of(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                    input logic [W-1:0] dd);
        return (aa[W-1] != bb[W-1]) && (dd[W-1] != aa[W-1]);
    endfunction

    // Called at posedge+1. Drives one cycle of inputs; if the edge samples a
    // real operation, its expected result is queued. The sampling edge loads
    // stage 0, so the result shows after LATENCY-1 further enabled edges.
    task automatic step(input logic e, input logic v, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic bi,
                        input logic [W-1:0] ed, input logic eb);
        exp_t x;
        en = e; in_valid = v; a = aa; b = bb; bin = bi;
        @(posedge clk);
        #1;
        if (e && v) begin
            x.d   = ed;
            x.bo  = eb;
            x.ov  = ovf_of(aa, bb, ed);
            x.due = ecnt + LATENCY - 1;
            sbq.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'hA, 4'h3, 1'b1, 4'h0, 1'b0);
    endtask

    task automatic check_out(input string name, input logic [W-1:0] ed, input logic eb,
                             input logic ev);
        ntests++;
        if (d !== ed || bout !== eb || out_valid !== ev) begin
            nfail++;
            $display("FAIL %s: got d=%0d bout=%b out_valid=%b, want d=%0d bout=%b out_valid=%b",
                     name, d, bout, out_valid, ed, eb, ev);
        end
    endtask

    // Monitor: one check per enabled edge, decoupled from the stimulus.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && ecnt != last_ecnt) begin
                last_ecnt = ecnt;
                if (out_valid) begin
                    ntests++;
                    if (sbq.size() == 0) begin
                        nfail++;
                        $display("FAIL unexpected_valid: got out_valid=1 d=%0d at edge %0d, want no result",
                                 d, ecnt);
                    end else begin
                        x = sbq.pop_front();
                        if (d !== x.d || bout !== x.bo || ecnt != x.due) begin
                            nfail++;
                            $display("FAIL result: got d=%0d bout=%b at edge %0d, want d=%0d bout=%b at edge %0d",
                                     d, bout, ecnt, x.d, x.bo, x.due);
                        end
`ifdef FPSUB_OVERFLOW_EN
                        ntests++;
                        if (ovf !== x.ov) begin
                            nfail++;
                            $display("FAIL ovf: got %b want %b (d=%0d)", ovf, x.ov, x.d);
                        end
`endif
                    end
                end else if (sbq.size() > 0 && sbq[0].due <= ecnt) begin
                    ntests++;
                    nfail++;
                    $display("FAIL missing_result: got out_valid=0 at edge %0d, want d=%0d due at edge %0d",
                             ecnt, sbq[0].d, sbq[0].due);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish earlier");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
        #12;
        check_out("reset_state", 4'd0, 1'b0, 1'b0);
`ifdef FPSUB_OVERFLOW_EN
        ntests++;
        if (ovf !== 1'b0) begin
            nfail++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, back to back.
        step(1'b1, 1'b1, 4'd9, 4'd3, 1'b0, 4'd6,  1'b0);
        step(1'b1, 1'b1, 4'd3, 4'd9, 1'b0, 4'd10, 1'b1);
        step(1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
        step(1'b1, 1'b1, 4'd7, 4'd8, 1'b0, 4'd15, 1'b1);
        step(1'b1, 1'b1, 4'd5, 4'd2, 1'b0, 4'd3,  1'b0);
        idle(W + 1);

        // Full-rate stream a=k, b=15-k.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b1, W'(k), W'(15 - k), 1'b0, W'(2 * k - 15), (k < 15 - k));
        end
        idle(W + 1);

        // Stall of three cycles with the pipe full; X2 (1-2 -> 15, borrow) sits at the output.
        step(1'b1, 1'b1, 4'd12, 4'd5, 1'b0, 4'd7,  1'b0);
        step(1'b1, 1'b1, 4'd1,  4'd2, 1'b0, 4'd15, 1'b1);
        step(1'b1, 1'b1, 4'd8,  4'd8, 1'b1, 4'd15, 1'b1);
        step(1'b1, 1'b1, 4'd15, 4'd0, 1'b1, 4'd14, 1'b0);
        step(1'b1, 1'b1, 4'd6,  4'd9, 1'b1, 4'd12, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'd0, 1'b0);
            check_out("stall_hold", 4'd15, 1'b1, 1'b1);
        end
        step(1'b1, 1'b1, 4'd10, 4'd4, 1'b0, 4'd6, 1'b0);
        idle(W + 1);

        // Reset with three operations in flight and R1 (2-7 -> 11) at the output.
        step(1'b1, 1'b1, 4'd2, 4'd7,  1'b0, 4'd11, 1'b1);
        step(1'b1, 1'b1, 4'd4, 4'd1,  1'b1, 4'd2,  1'b0);
        step(1'b1, 1'b1, 4'd0, 4'd15, 1'b0, 4'd1,  1'b1);
        step(1'b1, 1'b1, 4'd9, 4'd9,  1'b0, 4'd0,  1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_reset", 4'd0, 1'b0, 1'b0);
        sbq.delete();
        @(posedge clk);
        #1;
        check_out("reset_hold", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(W + 2);
        step(1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 4'd15, 1'b1);
        idle(W + 1);

        ntests++;
        if (sbq.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d results outstanding, want 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
